// File: rtl/clock_pkg.sv
// clock_pkg: shared types, field widths and time-field helpers for the
// 12-hour clock front end (clock_ctrl_12h and its sub-modules).
package clock_pkg;

    localparam int HOUR_W = 4;
    localparam int MIN_W  = 6;

    localparam logic [HOUR_W-1:0] HOUR_MIN = 4'd1;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 4'd12;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;

    // AL_* states are only reachable when the alarm feature is compiled in.
    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_COMMIT   = 3'd3,
        ST_AL_HOUR  = 3'd4,
        ST_AL_MIN   = 3'd5
    } state_t;

    // 12 -> 1, 1..11 -> +1; any out-of-range value also lands on 1.
    function automatic logic [HOUR_W-1:0] hour_step(input logic [HOUR_W-1:0] h);
        return (h >= HOUR_MAX || h < HOUR_MIN) ? HOUR_MIN : h + 4'd1;
    endfunction

    // 59 -> 0 with no carry into the hour field.
    function automatic logic [MIN_W-1:0] minute_step(input logic [MIN_W-1:0] m);
        return (m >= MIN_MAX) ? 6'd0 : m + 6'd1;
    endfunction

    // Keep captured counter values inside the legal range.
    function automatic logic [HOUR_W-1:0] hour_fix(input logic [HOUR_W-1:0] h);
        return (h > HOUR_MAX || h < HOUR_MIN) ? HOUR_MAX : h;
    endfunction

    function automatic logic [MIN_W-1:0] minute_fix(input logic [MIN_W-1:0] m);
        return (m > MIN_MAX) ? 6'd0 : m;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debounce and a one-cycle
// pulse on each accepted rising edge of an asynchronous active-high button.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 200_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int             CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic [CW-1:0] cnt;

    // Bring the raw button into the clk domain.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    // Accept a new level after DEBOUNCE_CYC consecutive differing samples; pulse on acceptance of a 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync_q2;
                press <= sync_q2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_ctrl_12h.sv
// clock_ctrl_12h: once-per-second count enable plus a two-button time-set
// FSM that issues a one-cycle load of hour/minute/AM-PM to the counter.
// Optional feature macro: CLOCK_CTRL_ALARM_EN (alarm set states, arm toggle
// in RUN, alarm_out match); when undefined alarm_out is tied to 0.
module clock_ctrl_12h
    import clock_pkg::*;
#(
    parameter int TICK_DIV     = 10_000_000,
    parameter int DEBOUNCE_CYC = 200_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_mode,
    input  logic              btn_inc,
    input  logic [HOUR_W-1:0] cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic              cur_am_pm,
    output logic              tick_en,
    output logic              load,
    output logic [HOUR_W-1:0] load_hours,
    output logic [MIN_W-1:0]  load_minutes,
    output logic              load_am_pm,
    output logic [1:0]        set_mode,
    output logic              blink,
    output logic              alarm_out
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE_HALF = PW'(TICK_DIV / 2);

    state_t            state;
    logic [PW-1:0]     pre;
    logic [HOUR_W-1:0] sh_hours;
    logic [MIN_W-1:0]  sh_minutes;
    logic              sh_am_pm;
    logic              mode_p;
    logic              inc_p;
    logic              editing;

`ifdef CLOCK_CTRL_ALARM_EN
    logic [HOUR_W-1:0] al_hours;
    logic [MIN_W-1:0]  al_minutes;
    logic              al_am_pm;
    logic              armed;
`endif

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_mode (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_mode),
        .press   (mode_p)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn_inc),
        .press   (inc_p)
    );

    // Prescaler: free-running wrap counter, held at 0 through COMMIT to re-phase the second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pre <= '0;
        else if (state == ST_COMMIT || pre == PRE_LAST)
            pre <= '0;
        else
            pre <= pre + 1'b1;
    end

    // Time-set FSM with its shadow (and alarm) registers; mode press wins over inc press.
    // NOTE: shadow registers are reset so load_* show 12:00 AM and a mid-edit reset discards edits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RUN;
            sh_hours   <= HOUR_MAX;
            sh_minutes <= '0;
            sh_am_pm   <= 1'b0;
`ifdef CLOCK_CTRL_ALARM_EN
            al_hours   <= HOUR_MAX;
            al_minutes <= '0;
            al_am_pm   <= 1'b0;
            armed      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_RUN: begin
                    if (mode_p) begin
                        sh_hours   <= hour_fix(cur_hours);
                        sh_minutes <= minute_fix(cur_minutes);
                        sh_am_pm   <= cur_am_pm;
                        state      <= ST_SET_HOUR;
                    end
`ifdef CLOCK_CTRL_ALARM_EN
                    else if (inc_p) begin
                        armed <= ~armed;
                    end
`endif
                end
                ST_SET_HOUR: begin
                    if (mode_p) begin
                        state <= ST_SET_MIN;
                    end else if (inc_p) begin
                        sh_hours <= hour_step(sh_hours);
                        if (sh_hours == HOUR_MAX - 4'd1)
                            sh_am_pm <= ~sh_am_pm;
                    end
                end
                ST_SET_MIN: begin
                    if (mode_p) begin
`ifdef CLOCK_CTRL_ALARM_EN
                        state <= ST_AL_HOUR;
`else
                        state <= ST_COMMIT;
`endif
                    end else if (inc_p) begin
                        sh_minutes <= minute_step(sh_minutes);
                    end
                end
`ifdef CLOCK_CTRL_ALARM_EN
                ST_AL_HOUR: begin
                    if (mode_p) begin
                        state <= ST_AL_MIN;
                    end else if (inc_p) begin
                        al_hours <= hour_step(al_hours);
                        if (al_hours == HOUR_MAX - 4'd1)
                            al_am_pm <= ~al_am_pm;
                    end
                end
                ST_AL_MIN: begin
                    if (mode_p)
                        state <= ST_COMMIT;
                    else if (inc_p)
                        al_minutes <= minute_step(al_minutes);
                end
`endif
                ST_COMMIT: state <= ST_RUN;
                default:   state <= ST_RUN;
            endcase
        end
    end

    // Decode the user-visible mode code from the state register.
    // NOTE: a default assignment first keeps this always_comb free of inferred latches.
    always_comb begin
        set_mode = 2'd0;
        case (state)
            ST_SET_HOUR, ST_AL_HOUR: set_mode = 2'd1;
            ST_SET_MIN, ST_AL_MIN:   set_mode = 2'd2;
            ST_COMMIT:               set_mode = 2'd3;
            default:                 set_mode = 2'd0;
        endcase
    end

    assign editing      = (state == ST_SET_HOUR) || (state == ST_SET_MIN) ||
                          (state == ST_AL_HOUR)  || (state == ST_AL_MIN);
    assign tick_en      = (state == ST_RUN) && (pre == PRE_LAST);
    assign blink        = editing && (pre < PRE_HALF);
    assign load         = (state == ST_COMMIT);
    assign load_hours   = sh_hours;
    assign load_minutes = sh_minutes;
    assign load_am_pm   = sh_am_pm;

`ifdef CLOCK_CTRL_ALARM_EN
    assign alarm_out = (state == ST_AL_HOUR || state == ST_AL_MIN) ? (pre < PRE_HALF) :
                       (armed && cur_hours == al_hours && cur_minutes == al_minutes &&
                        cur_am_pm == al_am_pm);
`else
    assign alarm_out = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl_12h.sv
// tb_clock_ctrl_12h: directed bench for clock_ctrl_12h with TICK_DIV=10,
// DEBOUNCE_CYC=4. Define CLOCK_CTRL_ALARM_EN to also run the alarm steps.
module tb_clock_ctrl_12h;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_hours;
    logic [5:0] cur_minutes;
    logic       cur_am_pm;
    logic       tick_en;
    logic       load;
    logic [3:0] load_hours;
    logic [5:0] load_minutes;
    logic       load_am_pm;
    logic [1:0] set_mode;
    logic       blink;
    logic       alarm_out;

    int vectors     = 0;
    int miscompares = 0;

    // Event log filled at each falling edge.
    int         cyc           = 0;
    int         load_cnt      = 0;
    int         load_cyc      = -100;
    int         last_tick_cyc = -100;
    logic [3:0] ld_h;
    logic [5:0] ld_m;
    logic       ld_ap;
    logic [1:0] sm_at_load;
    logic [1:0] sm_after_load;

    clock_ctrl_12h #(.TICK_DIV(10), .DEBOUNCE_CYC(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_mode     (btn_mode),
        .btn_inc      (btn_inc),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_am_pm    (cur_am_pm),
        .tick_en      (tick_en),
        .load         (load),
        .load_hours   (load_hours),
        .load_minutes (load_minutes),
        .load_am_pm   (load_am_pm),
        .set_mode     (set_mode),
        .blink        (blink),
        .alarm_out    (alarm_out)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (load) begin
            load_cnt   = load_cnt + 1;
            load_cyc   = cyc;
            ld_h       = load_hours;
            ld_m       = load_minutes;
            ld_ap      = load_am_pm;
            sm_at_load = set_mode;
        end
        if (cyc == load_cyc + 1)
            sm_after_load = set_mode;
        if (tick_en)
            last_tick_cyc = cyc;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Hold the chosen buttons for 10 cycles, release for 10; ends just after a falling edge.
    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (10) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (10) @(negedge clk);
        #2;
    endtask

    initial begin
        int blink_cnt;
        int tick_cnt;
        int loads_before;

        rst_n       = 1'b0;
        btn_mode    = 1'b0;
        btn_inc     = 1'b0;
        cur_hours   = 4'd12;
        cur_minutes = 6'd0;
        cur_am_pm   = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_tick", tick_en, 0);
        check("rst_load", load, 0);
        check("rst_blink", blink, 0);
        check("rst_hours", load_hours, 12);
        check("rst_minutes", load_minutes, 0);
        check("rst_am_pm", load_am_pm, 0);
        check("rst_set_mode", set_mode, 0);
        check("rst_alarm", alarm_out, 0);

        // Idle run: tick in cycles 10, 20, 30 after release.
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("idle_tick_%0d", k), tick_en, (k % 10 == 9) ? 1 : 0);
            check("idle_load", load, 0);
            if (k < 9) begin
                check("idle_hours", load_hours, 12);
                check("idle_set_mode", set_mode, 0);
                check("idle_blink", blink, 0);
            end
        end
        #2;
        check("idle_no_load", load_cnt, 0);

        // 11:59 AM -> 12:59 PM edit and commit.
        cur_hours   = 4'd11;
        cur_minutes = 6'd59;
        cur_am_pm   = 1'b0;
        press(1'b1, 1'b0);
        check("sethour_mode", set_mode, 1);
        check("capture_hours", load_hours, 11);
        check("capture_minutes", load_minutes, 59);
        check("capture_am_pm", load_am_pm, 0);
        blink_cnt = 0;
        tick_cnt  = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            blink_cnt += int'(blink);
            tick_cnt  += int'(tick_en);
        end
        #2;
        check("sethour_blink_duty", blink_cnt, 5);
        check("sethour_no_tick", tick_cnt, 0);
        press(1'b0, 1'b1);
        check("hour_11_to_12", load_hours, 12);
        check("hour_11_am_pm", load_am_pm, 1);
        press(1'b1, 1'b0);
        check("setmin_mode", set_mode, 2);
        press(1'b1, 1'b0);
        check("commit_load_cnt", load_cnt, 1);
        check("commit_hours", ld_h, 12);
        check("commit_minutes", ld_m, 59);
        check("commit_am_pm", ld_ap, 1);
        check("commit_set_mode", sm_at_load, 3);
        check("after_commit_mode", sm_after_load, 0);
        check("tick_after_commit", last_tick_cyc - load_cyc, 10);

        // Minute wrap from 58 at 10:58 PM.
        cur_hours   = 4'd10;
        cur_minutes = 6'd58;
        cur_am_pm   = 1'b1;
        press(1'b1, 1'b0);
        check("cap2_hours", load_hours, 10);
        check("cap2_am_pm", load_am_pm, 1);
        press(1'b1, 1'b0);
        check("setmin2_mode", set_mode, 2);
        press(1'b0, 1'b1);
        check("min_58_to_59", load_minutes, 59);
        press(1'b0, 1'b1);
        check("min_59_to_0", load_minutes, 0);
        press(1'b0, 1'b1);
        check("min_0_to_1", load_minutes, 1);
        check("min_no_carry", load_hours, 10);
        check("min_am_pm_kept", load_am_pm, 1);

        // Short glitch on btn_inc is rejected.
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (3) @(negedge clk);
        btn_inc = 1'b0;
        repeat (15) @(negedge clk);
        #2;
        check("glitch_minutes", load_minutes, 1);
        check("glitch_mode", set_mode, 2);

        // Commit 10:01 PM.
        press(1'b1, 1'b0);
        check("commit2_load_cnt", load_cnt, 2);
        check("commit2_hours", ld_h, 10);
        check("commit2_minutes", ld_m, 1);
        check("commit2_am_pm", ld_ap, 1);
        check("run_again", set_mode, 0);

        // Mode and inc together in SET_HOUR: mode wins.
        press(1'b1, 1'b0);
        check("sethour3_mode", set_mode, 1);
        press(1'b1, 1'b1);
        check("both_mode", set_mode, 2);
        check("both_hours", load_hours, 10);
        check("both_am_pm", load_am_pm, 1);

        // Reset mid-edit discards everything.
        loads_before = load_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_mode", set_mode, 0);
        check("midrst_load", load, 0);
        check("midrst_hours", load_hours, 12);
        check("midrst_minutes", load_minutes, 0);
        check("midrst_am_pm", load_am_pm, 0);
        check("midrst_blink", blink, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        #2;
        check("midrst_no_load", load_cnt, loads_before);
        check("midrst_run", set_mode, 0);

`ifdef CLOCK_CTRL_ALARM_EN
        // Alarm at 1:00 PM: walk through time fields, then step alarm hour 12 AM -> 1 PM.
        cur_hours   = 4'd3;
        cur_minutes = 6'd0;
        cur_am_pm   = 1'b0;
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        check("al_hour_mode", set_mode, 1);
        for (int k = 0; k < 13; k++)
            press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        check("al_min_mode", set_mode, 2);
        press(1'b1, 1'b0);
        check("al_commit_run", set_mode, 0);
        press(1'b0, 1'b1);
        cur_hours   = 4'd1;
        cur_minutes = 6'd0;
        cur_am_pm   = 1'b1;
        #1;
        check("alarm_match", alarm_out, 1);
        cur_minutes = 6'd1;
        #1;
        check("alarm_nomatch", alarm_out, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
